// File: rtl/ara_dram_preload_ctrl.sv
// rtl/ara_dram_preload_ctrl.sv - ELF image preload sequencer issuing range-checked DRAM row writes
//
// Purpose : accepts section descriptors and row-wide data beats from a host/debug
//           stream, writes each in-window row to the DRAM write port, and holds the
//           core in reset until the final section has been committed.
// Ports   : clk_i, rst_ni            clock, asynchronous active-low reset
//           sec_*                    section descriptor handshake (addr, len, last)
//           data_valid_i/ready_o/i   row data beats, byte b at [8b+:8]
//           mem_req_o/gnt_i/addr_o/wdata_o/be_o   DRAM row write port
//           core_rst_no, done_o      core reset release / image complete
//           err_o, err_cnt_o         sticky error flag, saturating event count
// Option  : ARA_PRELOAD_BE_TRIM_EN   trims byte enables on the first (misaligned)
//           and last (partial) row of a section; otherwise mem_be_o is all ones.
module ara_dram_preload_ctrl #(
  parameter int unsigned               NrLanes      = 4,
  parameter int unsigned               AxiAddrWidth = 64,
  parameter int unsigned               AxiDataWidth = 64 * NrLanes / 2,
  parameter logic [AxiAddrWidth-1:0]   DRAMAddrBase = 64'h8000_0000,
  parameter logic [AxiAddrWidth-1:0]   DRAMLength   = 64'h4000_0000
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        sec_valid_i,
  output logic                        sec_ready_o,
  input  logic [AxiAddrWidth-1:0]     sec_addr_i,
  input  logic [AxiAddrWidth-1:0]     sec_len_i,
  input  logic                        sec_last_i,
  input  logic                        data_valid_i,
  output logic                        data_ready_o,
  input  logic [AxiDataWidth-1:0]     data_i,
  output logic                        mem_req_o,
  input  logic                        mem_gnt_i,
  output logic [AxiAddrWidth-1:0]     mem_addr_o,
  output logic [AxiDataWidth-1:0]     mem_wdata_o,
  output logic [AxiDataWidth/8-1:0]   mem_be_o,
  output logic                        core_rst_no,
  output logic                        done_o,
  output logic                        err_o,
  output logic [15:0]                 err_cnt_o
);

  localparam int unsigned BeWidth    = AxiDataWidth / 8;
  localparam int unsigned ByteOffset = $clog2(BeWidth);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                    r_state;
  logic [AxiAddrWidth-1:0]   r_sec_addr;
  logic [AxiAddrWidth-1:0]   r_nrows;
  logic [AxiAddrWidth-1:0]   r_w;
  logic                      r_last;
  logic                      r_sec_ready;
  logic                      r_data_ready;
  logic                      r_mem_req;
  logic [AxiAddrWidth-1:0]   r_mem_addr;
  logic [AxiDataWidth-1:0]   r_wdata;
  logic [BeWidth-1:0]        r_be;
  logic                      r_core_rst_n;
  logic                      r_done;
  logic                      r_err;
  logic [15:0]               r_err_cnt;
`ifdef ARA_PRELOAD_BE_TRIM_EN
  logic [ByteOffset-1:0]     r_len_rem;
  logic [ByteOffset-1:0]     r_misalign;
`endif

  logic [AxiAddrWidth-1:0]   w_nrows;
  logic [AxiAddrWidth-1:0]   w_row_byte;
  logic [AxiAddrWidth-1:0]   w_row_idx;
  logic [AxiAddrWidth-1:0]   w_dram_end;
  logic [AxiAddrWidth-1:0]   w_w_next;
  logic                      w_in_range;
  logic                      w_last_row;
  logic                      w_misaligned;
  logic                      w_sec_hs;
  logic                      w_beat;
  logic [15:0]               w_err_cnt_inc;
  logic [BeWidth-1:0]        w_be;

  // ceil(len/BeWidth); the add wraps at full width by design
  assign w_nrows       = (sec_len_i + AxiAddrWidth'(BeWidth - 1)) >> ByteOffset;
  assign w_row_byte    = r_sec_addr + (r_w << ByteOffset);
  assign w_dram_end    = DRAMAddrBase + DRAMLength;
  assign w_in_range    = (w_row_byte >= DRAMAddrBase) && (w_row_byte < w_dram_end);
  // a misaligned section lands on the floored row index
  assign w_row_idx     = (w_row_byte - DRAMAddrBase) >> ByteOffset;
  assign w_w_next      = r_w + AxiAddrWidth'(1);
  assign w_last_row    = (w_w_next == r_nrows);
  assign w_misaligned  = |sec_addr_i[ByteOffset-1:0];
  assign w_sec_hs      = sec_valid_i & r_sec_ready;
  assign w_beat        = data_valid_i & r_data_ready;
  assign w_err_cnt_inc = (&r_err_cnt) ? r_err_cnt : r_err_cnt + 16'd1;

`ifdef ARA_PRELOAD_BE_TRIM_EN
  logic [BeWidth-1:0] w_be_head;
  logic [BeWidth-1:0] w_be_tail;
  assign w_be_head = (r_w == '0) ? ({BeWidth{1'b1}} << r_misalign) : {BeWidth{1'b1}};
  assign w_be_tail = (w_last_row && (r_len_rem != '0)) ? ~({BeWidth{1'b1}} << r_len_rem)
                                                       : {BeWidth{1'b1}};
  assign w_be      = w_be_head & w_be_tail;
`else
  assign w_be      = {BeWidth{1'b1}};
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_sec_addr   <= '0;
      r_nrows      <= '0;
      r_w          <= '0;
      r_last       <= 1'b0;
      r_sec_ready  <= 1'b0;
      r_data_ready <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_core_rst_n <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_err_cnt    <= '0;
`ifdef ARA_PRELOAD_BE_TRIM_EN
      r_len_rem    <= '0;
      r_misalign   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          // ready comes up one cycle after reset release or section end
          r_sec_ready <= 1'b1;
          if (w_sec_hs) begin
            r_sec_addr <= sec_addr_i;
            r_last     <= sec_last_i;
            r_nrows    <= w_nrows;
            r_w        <= '0;
`ifdef ARA_PRELOAD_BE_TRIM_EN
            r_len_rem  <= sec_len_i[ByteOffset-1:0];
            r_misalign <= sec_addr_i[ByteOffset-1:0];
`endif
            if (w_misaligned) begin
              r_err     <= 1'b1;
              r_err_cnt <= w_err_cnt_inc;
            end
            if (sec_len_i == '0) begin
              if (sec_last_i) begin
                r_state      <= S_DONE;
                r_sec_ready  <= 1'b0;
                r_done       <= 1'b1;
                r_core_rst_n <= 1'b1;
              end
            end else begin
              r_state      <= S_DATA;
              r_sec_ready  <= 1'b0;
              r_data_ready <= 1'b1;
            end
          end
        end

        S_DATA: begin
          if (w_beat) begin
            if (w_in_range) begin
              r_state      <= S_WRITE;
              r_data_ready <= 1'b0;
              r_mem_req    <= 1'b1;
              r_mem_addr   <= w_row_idx;
              r_wdata      <= data_i;
              r_be         <= w_be;
            end else begin
              // out-of-window row: consume and drop, one row per cycle
              r_err     <= 1'b1;
              r_err_cnt <= w_err_cnt_inc;
              r_w       <= w_w_next;
              if (w_last_row) begin
                r_data_ready <= 1'b0;
                if (r_last) begin
                  r_state      <= S_DONE;
                  r_done       <= 1'b1;
                  r_core_rst_n <= 1'b1;
                end else begin
                  r_state     <= S_IDLE;
                  r_sec_ready <= 1'b1;
                end
              end
            end
          end
        end

        S_WRITE: begin
          // request, address, data and BE stay frozen until granted
          if (mem_gnt_i) begin
            r_mem_req <= 1'b0;
            r_w       <= w_w_next;
            if (w_last_row) begin
              if (r_last) begin
                r_state      <= S_DONE;
                r_done       <= 1'b1;
                r_core_rst_n <= 1'b1;
              end else begin
                r_state     <= S_IDLE;
                r_sec_ready <= 1'b1;
              end
            end else begin
              r_state      <= S_DATA;
              r_data_ready <= 1'b1;
            end
          end
        end

        S_DONE: begin
          r_sec_ready  <= 1'b0;
          r_data_ready <= 1'b0;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sec_ready_o  = r_sec_ready;
  assign data_ready_o = r_data_ready;
  assign mem_req_o    = r_mem_req;
  assign mem_addr_o   = r_mem_addr;
  assign mem_wdata_o  = r_wdata;
  assign mem_be_o     = r_be;
  assign core_rst_no  = r_core_rst_n;
  assign done_o       = r_done;
  assign err_o        = r_err;
  assign err_cnt_o    = r_err_cnt;

endmodule

// File: tb/tb_ara_dram_preload_ctrl.sv
// tb/tb_ara_dram_preload_ctrl.sv - randomized self-checking bench for ara_dram_preload_ctrl
module tb_ara_dram_preload_ctrl;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] DLEN = 64'h4000_0000;

  typedef struct {
    logic [63:0]  idx;
    logic [127:0] data;
    logic [15:0]  be;
  } wr_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sec_valid;
  logic         sec_ready;
  logic [63:0]  sec_addr;
  logic [63:0]  sec_len;
  logic         sec_last;
  logic         data_valid;
  logic         data_ready;
  logic [127:0] data_in;
  logic         mem_req;
  logic         mem_gnt;
  logic [63:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [15:0]  mem_be;
  logic         core_rst_n;
  logic         done;
  logic         err;
  logic [15:0]  err_cnt;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  m_err = 0;
  wr_t exp_q[$];
  wr_t act_q[$];

  always #5 clk = ~clk;

  ara_dram_preload_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .sec_valid_i  (sec_valid),
    .sec_ready_o  (sec_ready),
    .sec_addr_i   (sec_addr),
    .sec_len_i    (sec_len),
    .sec_last_i   (sec_last),
    .data_valid_i (data_valid),
    .data_ready_o (data_ready),
    .data_i       (data_in),
    .mem_req_o    (mem_req),
    .mem_gnt_i    (mem_gnt),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_be_o     (mem_be),
    .core_rst_no  (core_rst_n),
    .done_o       (done),
    .err_o        (err),
    .err_cnt_o    (err_cnt)
  );

  function automatic logic [15:0] model_be(input logic [63:0] addr, input logic [63:0] len,
                                           input int w, input int nrows);
    logic [15:0] be;
    be = 16'hFFFF;
`ifdef ARA_PRELOAD_BE_TRIM_EN
    for (int b = 0; b < 16; b++) begin
      if (w == 0 && b < int'(addr % 16)) be[b] = 1'b0;
      if (w == nrows - 1 && (len % 16) != 0 && b >= int'(len % 16)) be[b] = 1'b0;
    end
`endif
    return be;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; sec_valid = 1'b0; data_valid = 1'b0; mem_gnt = 1'b0;
    sec_addr = '0; sec_len = '0; sec_last = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_err = 0;
  endtask

  // gnt_mode: 0 tied high, 1 random 60%, 2 withheld 5 cycles per write
  task automatic run_section(input logic [63:0] addr, input logic [63:0] len,
                             input logic last, input int gnt_mode);
    logic [127:0] rows[$];
    logic [63:0]  a;
    logic [63:0]  prev_addr;
    logic [127:0] prev_data;
    logic         prev_req;
    wr_t          e;
    wr_t          got;
    int           nrows, sent, cyc, hold;
    bit           fin;
    exp_q.delete(); act_q.delete();
    nrows = int'((len + 15) / 16);
    if (addr % 16 != 0) m_err++;
    for (int w = 0; w < nrows; w++) begin
      rows.push_back({$urandom, $urandom, $urandom, $urandom});
      a = addr + 64'(w) * 16;
      if (a >= BASE && a < BASE + DLEN) begin
        e.idx = (a - BASE) / 16; e.data = rows[w]; e.be = model_be(addr, len, w, nrows);
        exp_q.push_back(e);
      end else m_err++;
    end
    @(posedge clk); #1;
    sec_valid = 1'b1; sec_addr = addr; sec_len = len; sec_last = last;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!sec_ready && cyc < 20);
    n_cmp++;
    if (sec_ready !== 1'b1) begin
      n_bad++; $display("FAIL sec_handshake: sec_ready_o=%b required 1", sec_ready);
      sec_valid = 1'b0; return;
    end
    @(posedge clk); #1 sec_valid = 1'b0;
    sent = 0; cyc = 0; hold = 0; prev_req = 1'b0; fin = 1'b0;
    prev_addr = '0; prev_data = '0;
    while (!fin && cyc < 400) begin
      data_valid = (sent < nrows);
      data_in    = (sent < nrows) ? rows[sent] : '0;
      case (gnt_mode)
        0:       mem_gnt = 1'b1;
        1:       mem_gnt = ($urandom_range(0, 99) < 60);
        default: mem_gnt = (hold >= 5);
      endcase
      @(negedge clk); cyc++;
      if (prev_req) begin
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== prev_addr || mem_wdata !== prev_data) begin
          n_bad++;
          $display("FAIL req_hold: req=%b addr=%h required req=1 addr=%h, data stable",
                   mem_req, mem_addr, prev_addr);
        end
      end
      if (mem_req) begin
        n_cmp++;
        if (data_ready !== 1'b0) begin
          n_bad++; $display("FAIL ready_in_write: data_ready_o=%b required 0", data_ready);
        end
      end
      if (mem_req && mem_gnt) begin
        got.idx = mem_addr; got.data = mem_wdata; got.be = mem_be;
        act_q.push_back(got); hold = 0;
      end else if (mem_req) hold++;
      prev_req = mem_req && !mem_gnt; prev_addr = mem_addr; prev_data = mem_wdata;
      if (data_ready && data_valid) sent++;
      else if (sent == nrows && !mem_req && !data_ready) fin = 1'b1;
      if (!fin) begin
        n_cmp++;
        if (done !== 1'b0) begin
          n_bad++; $display("FAIL done_early: done_o=%b required 0", done);
        end
      end
      @(posedge clk); #1;
    end
    data_valid = 1'b0; mem_gnt = 1'b0;
    n_cmp++;
    if (!fin) begin
      n_bad++; $display("FAIL section_timeout: sent=%0d rows required %0d", sent, nrows);
    end
    n_cmp++;
    if (act_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL write_count: got %0d writes required %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (act_q[i].idx !== exp_q[i].idx || act_q[i].data !== exp_q[i].data || act_q[i].be !== exp_q[i].be) begin
        n_bad++;
        $display("FAIL write[%0d]: idx=%h be=%h data=%h required idx=%h be=%h data=%h", i,
                 act_q[i].idx, act_q[i].be, act_q[i].data, exp_q[i].idx, exp_q[i].be, exp_q[i].data);
      end
    end
    n_cmp++;
    if (done !== last || core_rst_n !== last || sec_ready !== !last) begin
      n_bad++;
      $display("FAIL section_end: done=%b core_rst_n=%b sec_ready=%b required %b %b %b",
               done, core_rst_n, sec_ready, last, last, !last);
    end
    n_cmp++;
    if (err !== (m_err != 0) || err_cnt !== 16'(m_err)) begin
      n_bad++;
      $display("FAIL err_state: err=%b err_cnt=%0d required %b %0d", err, err_cnt, (m_err != 0), m_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sec_valid = 1'b0; data_valid = 1'b0; mem_gnt = 1'b0;
    sec_addr = '0; sec_len = '0; sec_last = 1'b0; data_in = '0;
    #13;
    n_cmp++;
    if ({sec_ready, data_ready, mem_req, core_rst_n, done, err} !== 6'b0 || err_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%b drdy=%b req=%b crst=%b done=%b err=%b cnt=%0d required all 0",
               sec_ready, data_ready, mem_req, core_rst_n, done, err, err_cnt);
    end
    @(posedge clk); #1 rst_n = 1'b1; m_err = 0;
  endtask

  task automatic test_aligned();
    do_reset();
    run_section(BASE, 64'h40, 1'b1, 0);
  endtask

  task automatic test_be_trim();
    do_reset();
    run_section(BASE + 64'h100, 64'h13, 1'b0, 0);
    run_section(BASE + 64'h205, 64'h23, 1'b1, 1);
  endtask

  task automatic test_drop();
    do_reset();
    run_section(64'h7FFF_FFF0, 64'h20, 1'b0, 0);
    run_section(BASE + DLEN - 64'h20, 64'h40, 1'b1, 0);
  endtask

  task automatic test_stall();
    do_reset();
    run_section(BASE + 64'h200, 64'h30, 1'b1, 2);
  endtask

  task automatic test_two_sections();
    do_reset();
    run_section(BASE + 64'h40, 64'h25, 1'b0, 0);
    run_section(BASE + 64'h80, 64'h0, 1'b1, 0);
  endtask

  task automatic test_random();
    logic [63:0] addr;
    logic [63:0] len;
    do_reset();
    for (int s = 0; s < 8; s++) begin
      case ($urandom_range(0, 2))
        0:       addr = BASE - 64'($urandom_range(0, 6)) * 16;
        1:       addr = BASE + DLEN - 64'($urandom_range(0, 6)) * 16;
        default: addr = BASE + 64'($urandom_range(0, 32'hFFFF)) * 16;
      endcase
      if ($urandom_range(0, 1) == 1) addr = addr + 64'($urandom_range(0, 15));
      len = 64'($urandom_range(0, 8'h60));
      run_section(addr, len, 1'b0, 1);
    end
    run_section(BASE, 64'h0, 1'b1, 1);
  endtask

  task automatic test_reset_mid_write();
    int cyc;
    bit found;
    do_reset();
    @(posedge clk); #1;
    sec_valid = 1'b1; sec_addr = BASE + 64'h3; sec_len = 64'h40; sec_last = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!sec_ready && cyc < 20);
    @(posedge clk); #1 sec_valid = 1'b0;
    found = 1'b0; cyc = 0;
    while (!found && cyc < 50) begin
      data_valid = 1'b1; data_in = {$urandom, $urandom, $urandom, $urandom}; mem_gnt = 1'b1;
      @(negedge clk); cyc++;
      if (mem_req && mem_addr == 64'd2) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    n_cmp++;
    if (!found) begin
      n_bad++; $display("FAIL row2_write_reached: found=%b required 1", found);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0 || core_rst_n !== 1'b0 || done !== 1'b0 || err !== 1'b0 || err_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL async_reset: req=%b crst=%b done=%b err=%b cnt=%0d required 0 0 0 0 0",
               mem_req, core_rst_n, done, err, err_cnt);
    end
    data_valid = 1'b0; mem_gnt = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; m_err = 0;
    run_section(BASE + 64'h1000, 64'h20, 1'b1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_aligned();
    test_be_trim();
    test_drop();
    test_stall();
    test_two_sections();
    test_random();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
